// File: rtl/alu_share_arbiter_if.sv
// Requester and response channels of the shared-ALU arbiter.
// master: the two requesters plus the response consumer; slave: the arbiter.
interface alu_share_arbiter_if #(
   parameter int W = 4
);
   logic         req0_valid;
   logic         req0_ready;
   logic [2:0]   req0_op;
   logic [W-1:0] req0_a;
   logic [W-1:0] req0_b;

   logic         req1_valid;
   logic         req1_ready;
   logic [2:0]   req1_op;
   logic [W-1:0] req1_a;
   logic [W-1:0] req1_b;

   logic         resp_valid;
   logic         resp_ready;
   logic         resp_id;
   logic [W-1:0] resp_result;
   logic         resp_carry;
   logic         resp_overflow;
   logic         resp_zero;

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      input  req0_ready,
      output req1_valid, req1_op, req1_a, req1_b,
      input  req1_ready,
      input  resp_valid, resp_id, resp_result, resp_carry, resp_overflow, resp_zero,
      output resp_ready
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      output req0_ready,
      input  req1_valid, req1_op, req1_a, req1_b,
      output req1_ready,
      output resp_valid, resp_id, resp_result, resp_carry, resp_overflow, resp_zero,
      input  resp_ready
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU4 between two requesters.
// Operands are registered towards the ALU; result and flags are captured one
// cycle later and returned on a single tagged response channel.
module alu_share_arbiter #(
   parameter int W     = 4,
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   alu_share_arbiter_if.slave  bus,
   output logic [W-1:0]        alu_a,
   output logic [W-1:0]        alu_b,
   output logic [2:0]          alu_op,
   input  logic [W-1:0]        alu_result,
   input  logic                alu_carry,
   input  logic                alu_overflow,
   input  logic                alu_zero,
   output logic                busy,
   output logic [CNT_W-1:0]    op_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]   state;
   logic         last_grant;
   logic         grant_id;
   logic         grant_any;
   logic         grant;
   logic         resp_id;
   logic [W-1:0] resp_result;
   logic         resp_carry;
   logic         resp_overflow;
   logic         resp_zero;

   // Pick a winner in IDLE: alternate on contention, otherwise the lone requester.
   always_comb begin
      grant_any = 1'b0;
      grant     = 1'b0;
      if (state == S_IDLE) begin
         if (bus.req0_valid && bus.req1_valid) begin
            grant_any = 1'b1;
            grant     = ~last_grant;
         end else if (bus.req0_valid) begin
            grant_any = 1'b1;
            grant     = 1'b0;
         end else if (bus.req1_valid) begin
            grant_any = 1'b1;
            grant     = 1'b1;
         end
      end
   end

   assign bus.req0_ready    = grant_any && !grant;
   assign bus.req1_ready    = grant_any &&  grant;
   assign bus.resp_valid    = (state == S_RESP);
   assign bus.resp_id       = resp_id;
   assign bus.resp_result   = resp_result;
   assign bus.resp_carry    = resp_carry;
   assign bus.resp_overflow = resp_overflow;
   assign bus.resp_zero     = resp_zero;
   assign busy              = (state != S_IDLE);

   // Accept -> let the ALU settle one cycle -> hold the captured response until taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         last_grant    <= 1'b1;
         grant_id      <= 1'b0;
         alu_a         <= '0;
         alu_b         <= '0;
         alu_op        <= '0;
         resp_id       <= 1'b0;
         resp_result   <= '0;
         resp_carry    <= 1'b0;
         resp_overflow <= 1'b0;
         resp_zero     <= 1'b0;
         op_count      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_any) begin
                  alu_a      <= grant ? bus.req1_a  : bus.req0_a;
                  alu_b      <= grant ? bus.req1_b  : bus.req0_b;
                  alu_op     <= grant ? bus.req1_op : bus.req0_op;
                  grant_id   <= grant;
                  last_grant <= grant;
                  state      <= S_EXEC;
               end
            end
            S_EXEC: begin
               resp_result   <= alu_result;
               resp_carry    <= alu_carry;
               resp_overflow <= alu_overflow;
               resp_zero     <= alu_zero;
               resp_id       <= grant_id;
               state         <= S_RESP;
            end
            S_RESP: begin
               if (bus.resp_ready) begin
                  op_count <= op_count + CNT_W'(1);
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: accepted requests push their
// hand-computed response; a monitor pops and compares on each response handshake.
module tb_alu_share_arbiter;

   typedef struct {
      bit         id;
      logic [3:0] r;
      bit         c;
      bit         v;
      bit         z;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic [3:0] alu_a, alu_b, alu_result;
   logic [2:0] alu_op;
   logic       alu_carry, alu_overflow, alu_zero;
   logic       busy;
   logic [7:0] op_count;

   logic [3:0] w_alu_a, w_alu_b, w_alu_result;
   logic [2:0] w_alu_op;
   logic       w_alu_carry, w_alu_overflow, w_alu_zero;
   logic       w_busy;
   logic [1:0] w_op_count;

   int         checks   = 0;
   int         failures = 0;
   exp_t       exp_q[$];
   bit         resp_ids[$];
   int         exp_cnt  = 0;
   logic [3:0] e_r[2];
   bit         e_c[2];
   bit         e_v[2];
   bit         e_z[2];

   alu_share_arbiter_if #(.W(4)) m_if ();
   alu_share_arbiter_if #(.W(4)) w_if ();

   alu_share_arbiter #(.W(4), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .bus(m_if.slave),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_carry(alu_carry),
      .alu_overflow(alu_overflow), .alu_zero(alu_zero),
      .busy(busy), .op_count(op_count)
   );

   alu_share_arbiter #(.W(4), .CNT_W(2)) u_wrap (
      .clk(clk), .rst(rst), .bus(w_if.slave),
      .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_op(w_alu_op),
      .alu_result(w_alu_result), .alu_carry(w_alu_carry),
      .alu_overflow(w_alu_overflow), .alu_zero(w_alu_zero),
      .busy(w_busy), .op_count(w_op_count)
   );

   always #5 clk = ~clk;

   // Stand-in ALU4: 000 add, 001 sub (carry = borrow), 010 and, 011 or, 100 xor, else not a.
   function automatic logic [6:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      logic [4:0] s;
      logic [3:0] r;
      logic       c;
      logic       v;
      s = '0;
      c = 1'b0;
      v = 1'b0;
      case (op)
         3'b000: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[3:0];
            c = s[4];
            v = (a[3] == b[3]) && (r[3] != a[3]);
         end
         3'b001: begin
            r = a - b;
            c = (a < b);
            v = (a[3] != b[3]) && (r[3] != a[3]);
         end
         3'b010:  r = a & b;
         3'b011:  r = a | b;
         3'b100:  r = a ^ b;
         default: r = ~a;
      endcase
      return {c, v, (r == 4'd0), r};
   endfunction

   // ALU models for both instances.
   always_comb {alu_carry, alu_overflow, alu_zero, alu_result} = alu_fn(alu_op, alu_a, alu_b);
   always_comb {w_alu_carry, w_alu_overflow, w_alu_zero, w_alu_result} = alu_fn(w_alu_op, w_alu_a, w_alu_b);

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic set_req(input bit id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] r, input bit c, input bit v, input bit z);
      e_r[id] = r;
      e_c[id] = c;
      e_v[id] = v;
      e_z[id] = z;
      if (id == 1'b0) begin
         m_if.req0_op = op; m_if.req0_a = a; m_if.req0_b = b; m_if.req0_valid = 1'b1;
      end else begin
         m_if.req1_op = op; m_if.req1_a = a; m_if.req1_b = b; m_if.req1_valid = 1'b1;
      end
   endtask

   task automatic clear_req(input bit id);
      if (id == 1'b0) m_if.req0_valid = 1'b0;
      else            m_if.req1_valid = 1'b0;
   endtask

   task automatic wait_ready(input bit id);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if ((id == 1'b0 && m_if.req0_ready) || (id == 1'b1 && m_if.req1_ready)) return;
      end
      chk(id ? "timeout_req1_ready" : "timeout_req0_ready", 0, 1);
   endtask

   task automatic send(input bit id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] r, input bit c, input bit v, input bit z);
      set_req(id, op, a, b, r, c, v, z);
      wait_ready(id);
      @(posedge clk); #1;
      clear_req(id);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) chk("timeout_drain", exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      resp_ids.delete();
      exp_cnt = 0;
   endtask

   // Scoreboard: push on acceptance, pop and compare on response handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("ready_exclusive", int'(m_if.req0_ready && m_if.req1_ready), 0);
            if (m_if.req0_valid && m_if.req0_ready)
               exp_q.push_back('{1'b0, e_r[0], e_c[0], e_v[0], e_z[0]});
            if (m_if.req1_valid && m_if.req1_ready)
               exp_q.push_back('{1'b1, e_r[1], e_c[1], e_v[1], e_z[1]});
            if (m_if.resp_valid && m_if.resp_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_resp", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("resp_id",       int'(m_if.resp_id),       int'(e.id));
                  chk("resp_result",   int'(m_if.resp_result),   int'(e.r));
                  chk("resp_carry",    int'(m_if.resp_carry),    int'(e.c));
                  chk("resp_overflow", int'(m_if.resp_overflow), int'(e.v));
                  chk("resp_zero",     int'(m_if.resp_zero),     int'(e.z));
                  chk("op_count_at_hs", int'(op_count), exp_cnt);
                  exp_cnt = (exp_cnt + 1) % 256;
                  resp_ids.push_back(m_if.resp_id);
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int wrap_exp[5];
      wrap_exp = '{1, 2, 3, 0, 1};

      m_if.req0_valid = 1'b0; m_if.req0_op = '0; m_if.req0_a = '0; m_if.req0_b = '0;
      m_if.req1_valid = 1'b0; m_if.req1_op = '0; m_if.req1_a = '0; m_if.req1_b = '0;
      m_if.resp_ready = 1'b0;
      w_if.req0_valid = 1'b0; w_if.req0_op = '0; w_if.req0_a = '0; w_if.req0_b = '0;
      w_if.req1_valid = 1'b0; w_if.req1_op = '0; w_if.req1_a = '0; w_if.req1_b = '0;
      w_if.resp_ready = 1'b1;

      do_reset();

      // Reset state
      @(negedge clk);
      chk("rst_alu_a", int'(alu_a), 0);
      chk("rst_alu_b", int'(alu_b), 0);
      chk("rst_alu_op", int'(alu_op), 0);
      chk("rst_resp_valid", int'(m_if.resp_valid), 0);
      chk("rst_resp_result", int'(m_if.resp_result), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_op_count", int'(op_count), 0);
      chk("rst_ready", int'({m_if.req0_ready, m_if.req1_ready}), 0);

      // Single op with latency check: 3 + 4
      @(posedge clk); #1;
      m_if.resp_ready = 1'b1;
      set_req(1'b0, 3'b000, 4'd3, 4'd4, 4'd7, 1'b0, 1'b0, 1'b0);
      wait_ready(1'b0);
      @(posedge clk); #1;
      clear_req(1'b0);
      @(negedge clk);
      chk("lat_exec_resp_valid", int'(m_if.resp_valid), 0);
      chk("lat_exec_busy", int'(busy), 1);
      @(negedge clk);
      chk("lat_resp_valid", int'(m_if.resp_valid), 1);
      @(negedge clk);
      chk("single_op_count", int'(op_count), 1);
      chk("single_resp_valid_drop", int'(m_if.resp_valid), 0);
      wait_drain();

      // Both requesters continuously valid: strict alternation starting at 0
      do_reset();
      m_if.resp_ready = 1'b1;
      fork
         for (int i = 0; i < 5; i++) send(1'b0, 3'b001, 4'd5, 4'd5, 4'd0, 1'b0, 1'b0, 1'b1);
         for (int j = 0; j < 5; j++) send(1'b1, 3'b000, 4'd7, 4'd1, 4'd8, 1'b0, 1'b1, 1'b0);
      join
      wait_drain();
      chk("alt_count", resp_ids.size(), 10);
      for (int k = 0; k < resp_ids.size(); k++) chk("alt_id_order", int'(resp_ids[k]), k % 2);

      // Backpressure: response held stable, no acceptance while stalled
      m_if.resp_ready = 1'b0;
      send(1'b0, 3'b010, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0);
      set_req(1'b1, 3'b011, 4'h5, 4'h2, 4'h7, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20 && !m_if.resp_valid; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("bp_resp_valid", int'(m_if.resp_valid), 1);
         chk("bp_resp_result", int'(m_if.resp_result), 8);
         chk("bp_resp_id", int'(m_if.resp_id), 0);
         chk("bp_busy", int'(busy), 1);
         chk("bp_req1_ready", int'(m_if.req1_ready), 0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      m_if.resp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_next_accept", int'(m_if.req1_ready), 1);
      @(posedge clk); #1;
      clear_req(1'b1);
      wait_drain();

      // Carry capture: 0xF + 0x1 from requester 1
      send(1'b1, 3'b000, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1);
      wait_drain();

      // Reset during EXEC discards the op and restores last_grant
      set_req(1'b0, 3'b000, 4'd2, 4'd2, 4'd4, 1'b0, 1'b0, 1'b0);
      wait_ready(1'b0);
      @(posedge clk); #1;
      clear_req(1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      exp_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("midrst_resp_valid", int'(m_if.resp_valid), 0);
         chk("midrst_busy", int'(busy), 0);
      end
      chk("midrst_op_count", int'(op_count), 0);
      @(posedge clk); #1;
      set_req(1'b0, 3'b100, 4'h9, 4'h6, 4'hF, 1'b0, 1'b0, 1'b0);
      set_req(1'b1, 3'b001, 4'h2, 4'h3, 4'hF, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("midrst_grant0_ready0", int'(m_if.req0_ready), 1);
      chk("midrst_grant0_ready1", int'(m_if.req1_ready), 0);
      @(posedge clk); #1;
      clear_req(1'b0);
      wait_ready(1'b1);
      @(posedge clk); #1;
      clear_req(1'b1);
      wait_drain();

      // Counter wrap on the CNT_W=2 instance
      for (int k = 0; k < 5; k++) begin
         w_if.req0_op = 3'b000;
         w_if.req0_a = 4'(k);
         w_if.req0_b = 4'd1;
         w_if.req0_valid = 1'b1;
         begin : wait_w_ready
            for (int i = 0; i < 50; i++) begin
               @(negedge clk);
               if (w_if.req0_ready) disable wait_w_ready;
            end
            chk("timeout_wrap_ready", 0, 1);
         end
         @(posedge clk); #1;
         w_if.req0_valid = 1'b0;
         begin : wait_w_resp
            for (int i = 0; i < 50; i++) begin
               @(negedge clk);
               if (w_if.resp_valid) disable wait_w_resp;
            end
            chk("timeout_wrap_resp", 0, 1);
         end
         @(negedge clk);
         chk("wrap_op_count", int'(w_op_count), wrap_exp[k]);
         @(posedge clk); #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU4 instance between two requesters: requester 0 is the keyboard/control path, requester 1 is the switch/test path.
- Arbitration is round-robin, with valid/ready handshakes on both sides.
- Drives the ALU operand and option inputs from registers.
- Captures result and flags, then returns them on a single tagged response channel.
- Sits in top between the requesters and ALU4; resp_result also feeds bcd7seg.

Parameters:
W, 4, operand/result width; must match the ALU.
CNT_W, 8, width of the completed-operation counter.

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  synchronous reset, active-high.
req0_valid  input  1  requester 0 has an operation.
req0_ready  output  1  requester 0 operation accepted this cycle.
req0_op  input  3  requester 0 ALU option code.
req0_a  input  W  requester 0 operand A.
req0_b  input  W  requester 0 operand b.
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1.
alu_a  output  W  registered operand A to the ALU.
alu_b  output  W  registered operand b to the ALU.
alu_op  output  3  registered option to the ALU.
alu_result  input  W  ALU result (combinational from alu_a, alu_b, alu_op).
alu_carry, alu_overflow, alu_zero  input  1 each  ALU flags.
resp_valid  output  1  response held valid.
resp_ready  input  1  consumer accepts the response.
resp_id  output  1  which requester the response belongs to.
resp_result  output  W  captured result.
resp_carry, resp_overflow, resp_zero  output  1 each  captured flags.
busy  output  1  high in any state other than IDLE.
op_count  output  CNT_W  number of completed response handshakes; wraps modulo 2^CNT_W.

Behaviour:
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- Reset values: state=IDLE, last_grant=1 (requester 0 wins first), all other registers 0.
- Reset values of outputs: alu_a/alu_b/alu_op=0, resp_*=0, resp_valid=0, busy=0, op_count=0, req0_ready=req1_ready=0.
- Grant rule in IDLE:
  - Both valid: grant the requester != last_grant.
  - Only one valid: grant that one.
  - Neither valid: stay in IDLE.
- reqN_ready:
  - Combinational; high only in IDLE, only for the granted requester.
  - Never high for both requesters in the same cycle.
  - Never high outside IDLE.
  - May depend on reqN_valid.
- Accept cycle (IDLE with a grant): load alu_a/alu_b/alu_op from the granted requester, load grant_id, set last_grant=grant, go to EXEC.
- EXEC (1 cycle): the ALU settles on the registered inputs. Capture alu_result and the flags into resp_result/resp_carry/resp_overflow/resp_zero, set resp_id=grant_id, go to RESP.
- RESP:
  - resp_valid=1; all resp_* fields stay stable until the handshake.
  - On resp_valid && resp_ready: op_count+=1, go to IDLE.
  - resp_valid drops in the cycle after the handshake.
- Latency: accept edge -> resp_valid high 2 cycles later. Minimum issue interval is 3 cycles; there is no back-to-back acceptance.
- alu_a/alu_b/alu_op hold their last values outside the accept cycle; they change only on acceptance.
- Requester holding valid while not granted: it waits, and must keep op/a/b stable until its ready.
- Starvation-free: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- Backpressure: resp_ready low holds the FSM in RESP indefinitely; no new request is accepted while there.
- resp_ready asserted while not in RESP: ignored.
- op_count wraps 2^CNT_W-1 -> 0 with no flag.
- rst asserted mid-operation (EXEC or RESP): the in-flight op is discarded, no response is produced, all registers return to reset values on that edge.
- rst has priority over every other event in the same cycle.

Test Plan:
- Reset then single op: after rst, req0 op=000 (add), a=3, b=4 -> req0_ready high that cycle; 2 cycles later resp_valid=1, resp_id=0, resp_result=7, carry=0, zero=0; with resp_ready=1, op_count=1.
- Both valid from reset: req0 a=5 b=5 op=001 (sub); req1 a=7 b=1 op=000 (add); resp_ready tied 1 -> grant 0 first (result 0, zero=1), then 1 (result 8, overflow=1); 10 ops alternate ids 0,1,0,1...
- Backpressure: resp_ready low for 5 cycles in RESP -> resp_* stable, busy=1, no reqN_ready; resp_ready high -> returns to IDLE, next op accepted on the following cycle.
- Carry/overflow capture: req1 op=000, a=0xF, b=0x1 -> resp_result=0, carry=1, zero=1, resp_id=1.
- Reset mid-op: assert rst in the EXEC cycle -> no resp_valid ever appears for that op; op_count=0; next request is granted to requester 0 when both are valid.
- Counter wrap: with CNT_W=2, complete 5 ops -> op_count sequence 1,2,3,0,1.
